// File: rtl/fadd_arb.sv
// fadd_arb: round-robin arbiter sharing one 3-stage floating-point adder
// among NREQ requesters. One operation is in flight at a time:
// grant (IDLE) -> ISSUE -> WAIT1 -> WAIT2 -> DONE -> response next cycle.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/x/y       per-requester request and packed 32-bit operands
//   req_ready           one-hot grant pulse, operands sampled that cycle
//   rsp_valid           one-hot result pulse to the granted requester
//   rsp_rslt/rsp_flag   result and {NV,-,OF,UF,NX} flags, held between responses
//   fflags, fflags_clr  sticky OR of delivered flags, synchronous clear
//   busy                high while an operation is in flight
//   fa_req/fa_x/fa_y    start pulse and stable operands to the adder
//   fa_rslt/fa_flag     adder outputs, valid in DONE
module fadd_arb #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned DW   = 32,
    localparam int unsigned FW   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_x,
    input  logic [NREQ*DW-1:0] req_y,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rslt,
    output logic [FW-1:0]      rsp_flag,
    output logic [FW-1:0]      fflags,
    input  logic               fflags_clr,
    output logic               busy,
    output logic               fa_req,
    output logic [DW-1:0]      fa_x,
    output logic [DW-1:0]      fa_y,
    input  logic [DW-1:0]      fa_rslt,
    input  logic [FW-1:0]      fa_flag
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] grant_idx, cand;
    logic            grant_any;
    logic [DW-1:0]   x_q, x_d, y_q, y_d;
    logic [DW-1:0]   x_sel, y_sel;
    logic [DW-1:0]   rslt_q, rslt_d;
    logic [FW-1:0]   flag_q, flag_d;
    logic [FW-1:0]   fflags_q, fflags_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

    // Round-robin pick: first valid requester at or above ptr_q, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_q;
        cand      = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDXW'((32'(ptr_q) + i) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Operand select for the winning requester.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDXW'(i) == grant_idx) begin
                x_sel = req_x[i*DW +: DW];
                y_sel = req_y[i*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only IDLE waits; the rest is a fixed adder-latency walk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT1;
            WAIT1:   state_d = WAIT2;
            WAIT2:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; the grant must be seen in the request cycle.
    always_comb begin
        req_ready = '0;
        fa_req    = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (grant_any) req_ready[grant_idx] = 1'b1;
            end
            ISSUE:   fa_req = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: operand latch, pointer, response capture, sticky flags.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        rslt_d      = rslt_q;
        flag_d      = flag_q;
        rsp_valid_d = '0;
        fflags_d    = fflags_clr ? '0 : fflags_q;
        if (state_q == IDLE && grant_any) begin
            x_d   = x_sel;
            y_d   = y_sel;
            idx_d = grant_idx;
            ptr_d = IDXW'((32'(grant_idx) + 32'd1) % NREQ);
        end
        if (state_q == DONE) begin
            rsp_valid_d[idx_q] = 1'b1;
            rslt_d             = fa_rslt;
            flag_d             = fa_flag;
            // New flags survive a same-cycle clear.
            fflags_d           = fflags_d | fa_flag;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            rslt_q      <= '0;
            flag_q      <= '0;
            rsp_valid_q <= '0;
            fflags_q    <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            rslt_q      <= rslt_d;
            flag_q      <= flag_d;
            rsp_valid_q <= rsp_valid_d;
            fflags_q    <= fflags_d;
        end
    end

    assign fa_x      = x_q;
    assign fa_y      = y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rslt  = rslt_q;
    assign rsp_flag  = flag_q;
    assign fflags    = fflags_q;

endmodule

// File: tb/tb_fadd_arb.sv
// Bench for fadd_arb: requester agents with operand queues, a stand-in
// 3-edge adder, and a cycle-level reference model checked every cycle.
module tb_fadd_arb;

    localparam int unsigned NREQ = 4;
    localparam logic [NREQ-1:0] ONE = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*32-1:0] req_x = '0;
    logic [NREQ*32-1:0] req_y = '0;
    logic [NREQ-1:0]    req_ready, rsp_valid;
    logic [31:0]        rsp_rslt;
    logic [4:0]         rsp_flag, fflags;
    logic               fflags_clr = 1'b0;
    logic               busy, fa_req;
    logic [31:0]        fa_x, fa_y;
    logic [31:0]        fa_rslt = '0;
    logic [4:0]         fa_flag = '0;

    fadd_arb #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rslt(rsp_rslt), .rsp_flag(rsp_flag),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy),
        .fa_req(fa_req), .fa_x(fa_x), .fa_y(fa_y), .fa_rslt(fa_rslt), .fa_flag(fa_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stand-in adder: known IEEE cases from a table, arbitrary mixing otherwise.
    function automatic logic [36:0] fref(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h3F800000, 32'h40000000}: return {32'h40400000, 5'h00};
            {32'h3F800000, 32'h3F800000}: return {32'h40000000, 5'h00};
            {32'h7F800000, 32'hFF800000}: return {32'hFFC00000, 5'h10};
            {32'h7F7FFFFF, 32'h7F7FFFFF}: return {32'h7F800000, 5'h05};
            default:                      return {x + y, x[4:0] ^ y[9:5]};
        endcase
    endfunction

    // Adder samples operands at its last stage; result appears 3 edges after fa_req.
    logic [1:0] fa_pipe = '0;
    always @(posedge clk) begin
        fa_pipe <= {fa_pipe[0], fa_req};
        if (fa_pipe[1]) {fa_rslt, fa_flag} <= fref(fa_x, fa_y);
    end

    int m_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    // Reference model state: time of last grant and what it owes.
    bit          m_act = 0;
    int          m_g = 0, m_idx = 0, m_ptr = 0;
    logic [31:0] m_x = '0, m_y = '0, m_pr = '0, m_rslt = '0;
    logic [4:0]  m_pf = '0, m_flag = '0, m_ff = '0;

    // Observation logs for hand-computed checks.
    int          gnt_n = 0, rsp_n = 0;
    int          gnt_idx[256], gnt_cyc[256], rsp_idx[256], rsp_cyc[256];
    logic [31:0] rsp_r[256];
    logic [4:0]  rsp_f[256], rsp_ff[256];

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < int'(NREQ); i++) if (((v >> i) & ONE) != '0) r = i;
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] e_rdy, e_rv;
        int  k, rel;
        bit  idle, e_busy;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_fa_req",    32'(fa_req),    32'd0);
            chk("rst_busy",      32'(busy),      32'd0);
            chk("rst_fflags",    32'(fflags),    32'd0);
            chk("rst_rsp_rslt",  rsp_rslt,       32'd0);
            chk("rst_rsp_flag",  32'(rsp_flag),  32'd0);
            chk("rst_fa_x",      fa_x,           32'd0);
            chk("rst_fa_y",      fa_y,           32'd0);
            m_act = 0; m_ptr = 0; m_ff = '0; m_rslt = '0; m_flag = '0;
        end else begin
            rel    = m_cyc - m_g;
            idle   = !m_act || rel >= 5;
            e_busy = m_act && rel >= 1 && rel <= 4;
            k = -1;
            if (idle) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    int c;
                    c = (m_ptr + i) % int'(NREQ);
                    if (k < 0 && ((req_valid >> c) & ONE) != '0) k = c;
                end
            end
            e_rdy = (k >= 0) ? (ONE << k) : '0;
            e_rv  = (m_act && rel == 5) ? (ONE << m_idx) : '0;
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("fa_req",    32'(fa_req),    32'(m_act && rel == 1));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("rsp_rslt",  rsp_rslt,       m_rslt);
            chk("rsp_flag",  32'(rsp_flag),  32'(m_flag));
            chk("fflags",    32'(fflags),    32'(m_ff));
            if (e_busy) begin
                chk("fa_x", fa_x, m_x);
                chk("fa_y", fa_y, m_y);
            end
            if (req_ready != '0 && gnt_n < 256) begin
                gnt_idx[gnt_n] = oh2i(req_ready); gnt_cyc[gnt_n] = m_cyc; gnt_n++;
            end
            if (rsp_valid != '0 && rsp_n < 256) begin
                rsp_idx[rsp_n] = oh2i(rsp_valid); rsp_cyc[rsp_n] = m_cyc;
                rsp_r[rsp_n] = rsp_rslt; rsp_f[rsp_n] = rsp_flag; rsp_ff[rsp_n] = fflags;
                rsp_n++;
            end
            // Advance the model to the next cycle.
            m_ff = (fflags_clr ? 5'h00 : m_ff) | ((m_act && rel == 4) ? m_pf : 5'h00);
            if (m_act && rel == 4) begin
                m_rslt = m_pr;
                m_flag = m_pf;
            end
            if (k >= 0) begin
                m_act = 1; m_g = m_cyc; m_idx = k;
                m_x = 32'(req_x >> (k * 32));
                m_y = 32'(req_y >> (k * 32));
                {m_pr, m_pf} = fref(m_x, m_y);
                m_ptr = (k + 1) % int'(NREQ);
            end
        end
        m_cyc++;
    end

    // Requester agents: each presents the head of its queue until granted.
    logic [63:0] rq [NREQ][64];
    int          rq_h [NREQ];
    int          rq_t [NREQ];

    task automatic drive();
        for (int k = 0; k < int'(NREQ); k++) begin
            if (rq_h[k] != rq_t[k]) begin
                req_valid[k] = 1'b1;
                {req_x[k*32 +: 32], req_y[k*32 +: 32]} = rq[k][rq_h[k] % 64];
            end else begin
                req_valid[k] = 1'b0;
                req_x[k*32 +: 32] = $urandom;
                req_y[k*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic push(input int k, input logic [31:0] x, input logic [31:0] y);
        rq[k][rq_t[k] % 64] = {x, y};
        rq_t[k]++;
        drive();
    endtask

    task automatic step();
        logic [NREQ-1:0] seen;
        @(negedge clk);
        seen = req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < int'(NREQ); k++)
            if (((seen >> k) & ONE) != '0 && rq_h[k] != rq_t[k]) rq_h[k]++;
        drive();
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int b = budget;
        while (rsp_n < target && b > 0) begin step(); b--; end
        checks++;
        if (rsp_n < target) begin
            failures++;
            $display("FAIL wait_rsp: got %0d responses expected %0d", rsp_n, target);
        end
    endtask

    task automatic wait_gnt(input int target, input int budget);
        int b = budget;
        while (gnt_n < target && b > 0) begin step(); b--; end
        checks++;
        if (gnt_n < target) begin
            failures++;
            $display("FAIL wait_gnt: got %0d grants expected %0d", gnt_n, target);
        end
    endtask

    initial begin
        int g0, n0, c0;
        int seq[5];
        logic [63:0] sp[4];
        sp = '{{32'h3F800000, 32'h40000000}, {32'h3F800000, 32'h3F800000},
               {32'h7F800000, 32'hFF800000}, {32'h7F7FFFFF, 32'h7F7FFFFF}};
        for (int k = 0; k < int'(NREQ); k++) begin rq_h[k] = 0; rq_t[k] = 0; end
        rst = 1'b1;
        drive();
        repeat (3) step();
        rst = 1'b0;

        // 1.0 + 2.0 on requester 0, first cycle after reset.
        g0 = gnt_n; n0 = rsp_n; c0 = m_cyc;
        push(0, 32'h3F800000, 32'h40000000);
        wait_rsp(n0 + 1, 10);
        chk("t1_gnt_idx", 32'(gnt_idx[g0]), 32'd0);
        chk("t1_gnt_cyc", 32'(gnt_cyc[g0]), 32'(c0));
        chk("t1_rsp_idx", 32'(rsp_idx[n0]), 32'd0);
        chk("t1_latency", 32'(rsp_cyc[n0] - gnt_cyc[g0]), 32'd5);
        chk("t1_rslt",    rsp_r[n0], 32'h40400000);
        chk("t1_flag",    32'(rsp_f[n0]), 32'd0);

        // All four requesting after reset: 0,1,2,3 then 0 again, 5 cycles apart.
        rst = 1'b1; step(); step(); rst = 1'b0;
        g0 = gnt_n; n0 = rsp_n;
        push(0, 32'h3F800000, 32'h40000000);
        push(0, 32'h3F800000, 32'h3F800000);
        for (int k = 1; k < 4; k++) push(k, 32'h3F800000, 32'h40000000);
        wait_rsp(n0 + 5, 40);
        seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            chk("t2_gnt_idx", 32'(gnt_idx[g0 + i]), 32'(seq[i]));
            chk("t2_gnt_gap", 32'(gnt_cyc[g0 + i] - gnt_cyc[g0]), 32'(5 * i));
            chk("t2_rsp_idx", 32'(rsp_idx[n0 + i]), 32'(seq[i]));
            chk("t2_latency", 32'(rsp_cyc[n0 + i] - gnt_cyc[g0 + i]), 32'd5);
        end
        chk("t2_rslt_last", rsp_r[n0 + 4], 32'h40000000);

        // inf + -inf raises NV and it sticks through a clean add.
        n0 = rsp_n;
        push(2, 32'h7F800000, 32'hFF800000);
        push(2, 32'h3F800000, 32'h3F800000);
        wait_rsp(n0 + 2, 20);
        chk("t3_rslt0", rsp_r[n0], 32'hFFC00000);
        chk("t3_flag0", 32'(rsp_f[n0]), 32'h10);
        chk("t3_ff0",   32'(rsp_ff[n0]), 32'h10);
        chk("t3_rslt1", rsp_r[n0 + 1], 32'h40000000);
        chk("t3_ff1",   32'(rsp_ff[n0 + 1]), 32'h10);
        repeat (3) step();
        chk("t3_ff_hold", 32'(fflags), 32'h10);

        // Overflow with a clear landing in the DONE cycle keeps only new flags.
        g0 = gnt_n; n0 = rsp_n;
        push(1, 32'h7F7FFFFF, 32'h7F7FFFFF);
        wait_gnt(g0 + 1, 10);
        repeat (3) step();
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
        wait_rsp(n0 + 1, 10);
        chk("t4_rslt", rsp_r[n0], 32'h7F800000);
        chk("t4_flag", 32'(rsp_f[n0]), 32'h05);
        chk("t4_ff",   32'(rsp_ff[n0]), 32'h05);
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0; step();
        chk("t4_ff_clr", 32'(fflags), 32'h00);

        // Reset during WAIT1 abandons the operation and rewinds the pointer.
        g0 = gnt_n; n0 = rsp_n;
        push(3, 32'h3F800000, 32'h40000000);
        wait_gnt(g0 + 1, 10);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (8) step();
        chk("t5_no_rsp", 32'(rsp_n), 32'(n0));
        chk("t5_busy",   32'(busy), 32'd0);
        g0 = gnt_n;
        push(2, 32'h3F800000, 32'h3F800000);
        push(1, 32'h3F800000, 32'h40000000);
        wait_rsp(n0 + 2, 20);
        chk("t5_gnt0",    32'(gnt_idx[g0]), 32'd1);
        chk("t5_rslt0",   rsp_r[n0], 32'h40400000);
        chk("t5_latency", 32'(rsp_cyc[n0] - gnt_cyc[g0]), 32'd5);
        chk("t5_gnt1",    32'(gnt_idx[g0 + 1]), 32'd2);
        chk("t5_rslt1",   rsp_r[n0 + 1], 32'h40000000);

        // Random traffic, clears and occasional resets against the model.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = int'($urandom_range(0, 3));
                if (rq_t[k] - rq_h[k] < 4) begin
                    if ($urandom_range(0, 3) == 0) begin
                        logic [63:0] p;
                        p = sp[$urandom_range(0, 3)];
                        push(k, p[63:32], p[31:0]);
                    end else begin
                        push(k, $urandom, $urandom);
                    end
                end
            end
            fflags_clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        fflags_clr = 1'b0;
        repeat (100) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
